// File: rtl/dest_reg_pipe_pkg.sv
// Shared definitions for the destination-register pipeline.
//   ADDR_W_DEF   : default register address width
//   LINK_REG_DEF : default link register (written by JAL/JALR)
//   rd_sel_e     : reg_dst encoding that picks the destination field
package dest_reg_pipe_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int LINK_REG_DEF = 31;

    typedef enum logic [1:0] {
        RD_SEL_RT   = 2'b00,
        RD_SEL_RD   = 2'b01,
        RD_SEL_LINK = 2'b10,
        RD_SEL_NONE = 2'b11
    } rd_sel_e;

endpackage

// File: rtl/dest_hit_cmp.sv
// Compares one in-flight destination entry against one source operand query.
// Ports:
//   vld : entry will write the register file
//   dst : entry destination register
//   src : source operand being looked up
//   hit : entry holds a pending write to src (register 0 never hits)
import dest_reg_pipe_pkg::*;

module dest_hit_cmp #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              vld,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] src,
    output logic              hit
);

    // Register 0 is hard-wired, so a query for it must never forward.
    assign hit = vld & (dst == src) & (src != '0);

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline, stage 0 (EX) through stage STAGES-1 (WB).
// Picks the destination of each decoded instruction (Rt, Rd or the link
// register), carries it with its write flag down the pipe, and drives the
// register-file write port from the last stage. Per-stage hit vectors let the
// hazard/forwarding unit match source operands against in-flight writes.
// Ports:
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   rt, rd, reg_dst     : instruction fields and destination select
//   reg_write, in_valid : instruction writes the RF / decode holds a real instr
//   stall, flush        : hold decode (bubble into stage 1) / kill stage-0 entry
//   src_a, src_b        : source operand queries
//   wb_reg, wb_en       : register-file write address / enable (last stage)
//   stage_dst           : flattened per-stage destinations, stage 0 in LSBs
//   stage_vld           : per-stage "will write" flags
//   hit_a, hit_b        : per-stage pending-write matches for src_a / src_b
//
// Flow control: decode presents an instruction with in_valid. On an edge with
// stall=1 the instruction in stage 0 stays put (decode also holds and
// re-presents the same instruction next cycle) and stage 1 takes a bubble, so
// nothing is written twice. flush=1 replaces whatever would enter stage 0 with
// a bubble and leaves older stages shifting normally; flush beats stall for
// stage 0 only.
import dest_reg_pipe_pkg::*;

module dest_reg_pipe #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int STAGES   = 3,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        rt,
    input  logic [ADDR_W-1:0]        rd,
    input  logic [1:0]               reg_dst,
    input  logic                     reg_write,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        src_a,
    input  logic [ADDR_W-1:0]        src_b,
    output logic [ADDR_W-1:0]        wb_reg,
    output logic                     wb_en,
    output logic [STAGES*ADDR_W-1:0] stage_dst,
    output logic [STAGES-1:0]        stage_vld,
    output logic [STAGES-1:0]        hit_a,
    output logic [STAGES-1:0]        hit_b
);

    logic [ADDR_W-1:0] sel;
    logic              wr;
    logic [ADDR_W-1:0] cap_dst;

    logic [ADDR_W-1:0] dst_q [STAGES];
    logic [STAGES-1:0] vld_q;

    always_comb begin
        sel = '0;
        case (rd_sel_e'(reg_dst))
            RD_SEL_RT:   sel = rt;
            RD_SEL_RD:   sel = rd;
            RD_SEL_LINK: sel = ADDR_W'(LINK_REG);
            default:     sel = '0;
        endcase
    end

    assign wr      = in_valid & reg_write & (reg_dst != RD_SEL_NONE) & (sel != '0);
    // Non-writing entries are bubbles and carry dst=0, keeping stage_dst
    // deterministic regardless of the raw instruction fields.
    assign cap_dst = wr ? sel : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            // Stage 0: flush > stall (hold) > capture.
            if (flush) begin
                vld_q[0] <= 1'b0;
                dst_q[0] <= '0;
            end else if (!stall) begin
                vld_q[0] <= wr;
                dst_q[0] <= cap_dst;
            end

            // Stage 1 takes a bubble whenever stage 0 holds, otherwise shifts.
            if (stall) begin
                vld_q[1] <= 1'b0;
                dst_q[1] <= '0;
            end else begin
                vld_q[1] <= vld_q[0];
                dst_q[1] <= dst_q[0];
            end

            for (int k = 2; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                dst_q[k] <= dst_q[k-1];
            end
        end
    end

    assign stage_vld = vld_q;
    assign wb_en     = vld_q[STAGES-1];
    assign wb_reg    = dst_q[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign stage_dst[g*ADDR_W +: ADDR_W] = dst_q[g];

        dest_hit_cmp #(.ADDR_W(ADDR_W)) u_hit_a (
            .vld (vld_q[g]),
            .dst (dst_q[g]),
            .src (src_a),
            .hit (hit_a[g])
        );

        dest_hit_cmp #(.ADDR_W(ADDR_W)) u_hit_b (
            .vld (vld_q[g]),
            .dst (dst_q[g]),
            .src (src_b),
            .hit (hit_b[g])
        );
    end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Self-checking bench for dest_reg_pipe: a STAGES=3 instance driven from a
// vector table and hand-written multi-cycle sequences, a STAGES=4 instance
// sharing the same inputs for the latency check, and a random phase scored
// against an expected writeback queue.
module tb_dest_reg_pipe;

    localparam int AW = 5;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] rt, rd;
    logic [1:0]    reg_dst;
    logic          reg_write, in_valid, stall, flush;
    logic [AW-1:0] src_a, src_b;

    logic [AW-1:0]   wb_reg;
    logic            wb_en;
    logic [3*AW-1:0] stage_dst;
    logic [2:0]      stage_vld, hit_a, hit_b;

    logic [AW-1:0]   wb_reg4;
    logic            wb_en4;
    logic [4*AW-1:0] stage_dst4;
    logic [3:0]      stage_vld4, hit_a4, hit_b4;

    dest_reg_pipe #(.ADDR_W(AW), .STAGES(3), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .rt(rt), .rd(rd), .reg_dst(reg_dst),
        .reg_write(reg_write), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .wb_reg(wb_reg), .wb_en(wb_en),
        .stage_dst(stage_dst), .stage_vld(stage_vld), .hit_a(hit_a), .hit_b(hit_b)
    );

    dest_reg_pipe #(.ADDR_W(AW), .STAGES(4), .LINK_REG(31)) dut4 (
        .clk(clk), .rst_n(rst_n), .rt(rt), .rd(rd), .reg_dst(reg_dst),
        .reg_write(reg_write), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .wb_reg(wb_reg4), .wb_en(wb_en4),
        .stage_dst(stage_dst4), .stage_vld(stage_vld4), .hit_a(hit_a4), .hit_b(hit_b4)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [AW:0] exp_q[$];   // {wb_en, wb_reg} expected per cycle

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic rw, input logic [1:0] sel,
                         input logic [AW-1:0] t, input logic [AW-1:0] d,
                         input logic st, input logic fl);
        in_valid = iv; reg_write = rw; reg_dst = sel;
        rt = t; rd = d; stall = st; flush = fl;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        drive_idle();
        repeat (n) tick();
    endtask

    function automatic logic [3*AW-1:0] pack3(input logic [AW-1:0] d2, input logic [AW-1:0] d1,
                                              input logic [AW-1:0] d0);
        return {d2, d1, d0};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic          rst_n, in_valid, reg_write;
        logic [1:0]    reg_dst;
        logic [AW-1:0] rt, rd, src_a, src_b;
        logic [2:0]    e_vld;
        logic [3*AW-1:0] e_dst;
        logic          e_wb_en;
        logic [AW-1:0] e_wb_reg;
        logic [2:0]    e_hit_a, e_hit_b;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input string nm, input logic rn, input logic iv, input logic rw,
                                input logic [1:0] sel, input logic [AW-1:0] t, input logic [AW-1:0] d,
                                input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                                input logic [2:0] ev, input logic [3*AW-1:0] ed,
                                input logic ee, input logic [AW-1:0] er,
                                input logic [2:0] ha, input logic [2:0] hb);
        vec_t v;
        v.name = nm; v.rst_n = rn; v.in_valid = iv; v.reg_write = rw; v.reg_dst = sel;
        v.rt = t; v.rd = d; v.src_a = sa; v.src_b = sb;
        v.e_vld = ev; v.e_dst = ed; v.e_wb_en = ee; v.e_wb_reg = er;
        v.e_hit_a = ha; v.e_hit_b = hb;
        return v;
    endfunction

    initial begin
        logic [3*AW-1:0] m;
        logic [AW:0]     e;
        logic [AW-1:0]   sel_m;
        logic            wr_m;

        drive_idle();
        rst_n = 1'b0; src_a = '0; src_b = '0;

        //                 name        rn iv rw dst   rt  rd  sa  sb  vld     dst                  en wb  ha      hb
        vecs[0]  = mk("reset_0",     0, 1, 1, 2'b01, 0,  7,  7,  7,  3'b000, 0,                   0, 0,  3'b000, 3'b000);
        vecs[1]  = mk("reset_1",     0, 1, 1, 2'b01, 0,  7,  7,  7,  3'b000, 0,                   0, 0,  3'b000, 3'b000);
        vecs[2]  = mk("sel_rt",      1, 1, 1, 2'b00, 4,  9,  4,  0,  3'b001, pack3(0, 0, 4),      0, 0,  3'b001, 3'b000);
        vecs[3]  = mk("sel_rd",      1, 1, 1, 2'b01, 4,  9,  4,  9,  3'b011, pack3(0, 4, 9),      0, 0,  3'b010, 3'b001);
        vecs[4]  = mk("sel_link",    1, 1, 1, 2'b10, 4,  9,  4,  31, 3'b111, pack3(4, 9, 31),     1, 4,  3'b100, 3'b001);
        vecs[5]  = mk("sel_none",    1, 1, 1, 2'b11, 4,  9,  31, 9,  3'b110, pack3(9, 31, 0),     1, 9,  3'b010, 3'b100);
        vecs[6]  = mk("idle_0",      1, 0, 0, 2'b00, 0,  0,  31, 0,  3'b100, pack3(31, 0, 0),     1, 31, 3'b100, 3'b000);
        vecs[7]  = mk("idle_1",      1, 0, 0, 2'b00, 0,  0,  31, 0,  3'b000, 0,                   0, 0,  3'b000, 3'b000);
        vecs[8]  = mk("zero_reg",    1, 1, 1, 2'b01, 0,  0,  0,  0,  3'b000, 0,                   0, 0,  3'b000, 3'b000);
        vecs[9]  = mk("no_regwrite", 1, 1, 0, 2'b01, 0,  8,  8,  8,  3'b000, 0,                   0, 0,  3'b000, 3'b000);
        vecs[10] = mk("not_valid",   1, 0, 1, 2'b01, 0,  8,  8,  8,  3'b000, 0,                   0, 0,  3'b000, 3'b000);
        vecs[11] = mk("b2b_1",       1, 1, 1, 2'b01, 0,  6,  6,  6,  3'b001, pack3(0, 0, 6),      0, 0,  3'b001, 3'b001);
        vecs[12] = mk("b2b_2",       1, 1, 1, 2'b01, 0,  6,  6,  6,  3'b011, pack3(0, 6, 6),      0, 0,  3'b011, 3'b011);
        vecs[13] = mk("b2b_3",       1, 1, 1, 2'b01, 0,  6,  6,  6,  3'b111, pack3(6, 6, 6),      1, 6,  3'b111, 3'b111);
        vecs[14] = mk("b2b_src0",    1, 1, 1, 2'b01, 0,  6,  0,  6,  3'b111, pack3(6, 6, 6),      1, 6,  3'b000, 3'b111);

        for (int i = 0; i < 15; i++) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].in_valid, vecs[i].reg_write, vecs[i].reg_dst,
                  vecs[i].rt, vecs[i].rd, 1'b0, 1'b0);
            src_a = vecs[i].src_a; src_b = vecs[i].src_b;
            tick();
            m = '0;
            for (int s = 0; s < 3; s++) if (vecs[i].e_vld[s]) m[s*AW +: AW] = '1;
            check({vecs[i].name, ".vld"},   32'(stage_vld), 32'(vecs[i].e_vld));
            check({vecs[i].name, ".dst"},   32'(stage_dst & m), 32'(vecs[i].e_dst & m));
            check({vecs[i].name, ".wb_en"}, 32'(wb_en), 32'(vecs[i].e_wb_en));
            if (vecs[i].e_wb_en) check({vecs[i].name, ".wb_reg"}, 32'(wb_reg), 32'(vecs[i].e_wb_reg));
            check({vecs[i].name, ".hit_a"}, 32'(hit_a), 32'(vecs[i].e_hit_a));
            check({vecs[i].name, ".hit_b"}, 32'(hit_b), 32'(vecs[i].e_hit_b));
        end

        // ---------- stall: one-cycle hold, bubble into stage 1 ----------
        drain(3);
        src_a = 5'd5; src_b = 5'd0;
        drive(1, 1, 2'b01, 0, 5, 0, 0); tick();
        check("stall.cap_vld", 32'(stage_vld), 32'b001);
        drive(1, 1, 2'b01, 0, 10, 1, 0); tick();
        check("stall.hold_vld", 32'(stage_vld), 32'b001);
        check("stall.hold_dst", 32'(stage_dst), 32'(pack3(0, 0, 5)));
        check("stall.hold_hit_a", 32'(hit_a), 32'b001);
        drive_idle(); tick();
        check("stall.s1_vld", 32'(stage_vld), 32'b010);
        check("stall.s1_wb_en", 32'(wb_en), 32'd0);
        tick();
        check("stall.wb_en", 32'(wb_en), 32'd1);
        check("stall.wb_reg", 32'(wb_reg), 32'd5);
        tick();
        check("stall.wb_once", 32'(wb_en), 32'd0);

        // ---------- flush + hazard, then stall+flush together ----------
        drain(3);
        drive(1, 1, 2'b01, 0, 12, 0, 0); tick();
        src_a = 5'd12; src_b = 5'd13;
        drive(1, 1, 2'b01, 0, 13, 0, 1); tick();
        check("flush.vld", 32'(stage_vld), 32'b010);
        check("flush.dst", 32'(stage_dst), 32'(pack3(0, 12, 0)));
        check("flush.hit_a", 32'(hit_a), 32'b010);
        check("flush.hit_b", 32'(hit_b), 32'b000);
        drive(1, 1, 2'b01, 0, 14, 0, 0); tick();
        check("flush.wb_en", 32'(wb_en), 32'd1);
        check("flush.wb_reg", 32'(wb_reg), 32'd12);
        drive(1, 1, 2'b01, 0, 16, 0, 0); tick();
        check("fl_st.pre_vld", 32'(stage_vld), 32'b011);
        drive(1, 1, 2'b01, 0, 15, 1, 1); tick();
        check("fl_st.vld", 32'(stage_vld), 32'b100);
        check("fl_st.dst", 32'(stage_dst), 32'(pack3(14, 0, 0)));
        check("fl_st.wb_reg", 32'(wb_reg), 32'd14);

        // ---------- reset overrides stall and flush ----------
        drive(1, 1, 2'b01, 0, 3, 0, 0);
        repeat (3) tick();
        check("rst_ovr.full", 32'(stage_vld), 32'b111);
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1; tick();
        check("rst_ovr.vld", 32'(stage_vld), 32'b000);
        check("rst_ovr.dst", 32'(stage_dst), 32'd0);
        check("rst_ovr.wb_en", 32'(wb_en), 32'd0);
        rst_n = 1'b1;

        // ---------- STAGES=4 latency ----------
        drain(4);
        src_a = 5'd20; src_b = 5'd0;
        drive(1, 1, 2'b01, 0, 20, 0, 0); tick();
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lat4.wb_en_%0d", i), 32'(wb_en4), 32'(i == 3));
            check($sformatf("lat4.hit_a_%0d", i), 32'(hit_a4), (i < 4) ? (32'd1 << i) : 32'd0);
            if (i == 3) check("lat4.wb_reg", 32'(wb_reg4), 32'd20);
            tick();
        end

        // ---------- random phase, writeback stream vs expected queue ----------
        drain(3);
        exp_q.delete();
        repeat (2) exp_q.push_back('0);
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b0, 1'b0);
            case (reg_dst)
                2'b00:   sel_m = rt;
                2'b01:   sel_m = rd;
                2'b10:   sel_m = 5'd31;
                default: sel_m = 5'd0;
            endcase
            wr_m = in_valid & reg_write & (reg_dst != 2'b11) & (sel_m != 0);
            exp_q.push_back({wr_m, wr_m ? sel_m : 5'd0});
            tick();
            e = exp_q.pop_front();
            check($sformatf("rand.wb_en_%0d", i), 32'(wb_en), 32'(e[AW]));
            if (e[AW]) check($sformatf("rand.wb_reg_%0d", i), 32'(wb_reg), 32'(e[AW-1:0]));
        end

        // ---------- report ----------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
